// File: rtl/ssd_scan_decoder_pkg.sv
// Shared seven-segment display constants for the encode and decode paths,
// plus the scan-decoder state and decode-result types.
package ssd_scan_decoder_pkg;

  // All segments off on an active-low bus.
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Active-low {g,f,e,d,c,b,a} patterns; element i displays hex digit i.
  localparam logic [15:0][6:0] SEG_HEX = {
    7'h0E, 7'h06, 7'h21, 7'h46,   // F E d C
    7'h03, 7'h08, 7'h10, 7'h00,   // b A 9 8
    7'h78, 7'h02, 7'h12, 7'h19,   // 7 6 5 4
    7'h30, 7'h24, 7'h79, 7'h40    // 3 2 1 0
  };

  // Active-low anode codes {AN3,AN2,AN1,AN0}; element i selects digit i.
  localparam logic [3:0][3:0] AN_SEL = {4'b0111, 4'b1011, 4'b1101, 4'b1110};

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETTLE,
    S_HOLD
  } scan_state_e;

  typedef struct packed {
    logic [3:0] nib;
    logic       blank;
    logic       bad;
  } seg_dec_t;

endpackage

// File: rtl/ssd_scan_decoder_if.sv
// Multiplexed display bus as seen by the scan decoder: segment/anode inputs
// and the decoded frame snapshot outputs.
interface ssd_scan_decoder_if;
  logic [6:0] C;
  logic       AN3, AN2, AN1, AN0;
  logic [3:0] D3, D2, D1, D0;
  logic [3:0] blank;
  logic [3:0] bad;
  logic       frame_valid;
  logic       scan_lost;

  // Display driver side: drives the bus, observes the decoded snapshot.
  modport master (
    output C, AN3, AN2, AN1, AN0,
    input  D3, D2, D1, D0, blank, bad, frame_valid, scan_lost
  );

  // Decoder side.
  modport slave (
    input  C, AN3, AN2, AN1, AN0,
    output D3, D2, D1, D0, blank, bad, frame_valid, scan_lost
  );
endinterface

// File: rtl/ssd_scan_decoder_seg7_to_hex.sv
// Combinational seven-segment pattern to {nibble, blank, bad} decoder.
module seg7_to_hex
  import ssd_scan_decoder_pkg::*;
(
  input  logic [6:0] seg,
  output seg_dec_t   dec
);

  // Match against the shared hex table; all-off is blank, anything else bad.
  always_comb begin
    dec = '0;
    if (seg == SEG_BLANK) begin
      dec.blank = 1'b1;
    end else begin
      dec.bad = 1'b1;
      for (int unsigned i = 0; i < 16; i++) begin
        if (seg == SEG_HEX[i]) begin
          dec.nib = 4'(i);
          dec.bad = 1'b0;
        end
      end
    end
  end

endmodule

// File: rtl/ssd_scan_decoder.sv
// Multiplexed seven-segment scan decoder: synchronizes the bus, accepts one
// stable capture per digit dwell and publishes a four-digit frame snapshot.
module ssd_scan_decoder
  import ssd_scan_decoder_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES  = 16,
  parameter int unsigned TIMEOUT_CYCLES = 800000,
  parameter int unsigned CW             = 20
) (
  input  logic                clk,
  input  logic                rst,
  ssd_scan_decoder_if.slave   bus
);

  localparam int unsigned SW = $clog2(STABLE_CYCLES + 1);

  logic [10:0]      sync1_q, sync2_q, prev_q;
  scan_state_e      state_q, state_d;
  logic [SW-1:0]    stab_q, stab_d;
  logic [CW-1:0]    to_cnt_q, to_cnt_d;
  logic [3:0][3:0]  sh_nib_q, sh_nib_d;
  logic [3:0]       sh_blank_q, sh_blank_d, sh_bad_q, sh_bad_d;
  logic [3:0]       seen_q, seen_d;
  logic [3:0][3:0]  d_q, d_d;
  logic [3:0]       blank_q, blank_d, bad_q, bad_d;
  logic             fv_q, fv_d, lost_q, lost_d;

  logic [3:0]       an_s;
  logic [6:0]       c_s;
  logic             sel_ok, changed, capture, frame;
  logic [1:0]       sel_idx;
  seg_dec_t         dec;

  assign an_s    = sync2_q[10:7];
  assign c_s     = sync2_q[6:0];
  assign changed = (sync2_q != prev_q);

  seg7_to_hex u_dec (
    .seg (c_s),
    .dec (dec)
  );

  // Legal selection: exactly one anode low.
  always_comb begin
    sel_ok  = 1'b0;
    sel_idx = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      if (an_s == AN_SEL[i]) begin
        sel_ok  = 1'b1;
        sel_idx = 2'(i);
      end
    end
  end

  // Dwell tracking: the first legal sample counts as 1, capture on the
  // STABLE_CYCLES-th identical sample, then hold until the bus moves.
  always_comb begin
    state_d = state_q;
    stab_d  = stab_q;
    capture = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (sel_ok) begin
          state_d = S_SETTLE;
          stab_d  = SW'(1);
        end
      end
      S_SETTLE: begin
        if (changed) begin
          state_d = sel_ok ? S_SETTLE : S_IDLE;
          stab_d  = SW'(1);
        end else if (stab_q >= SW'(STABLE_CYCLES - 1)) begin
          capture = 1'b1;
          state_d = S_HOLD;
        end else begin
          stab_d = stab_q + SW'(1);
        end
      end
      S_HOLD: begin
        if (changed) begin
          state_d = sel_ok ? S_SETTLE : S_IDLE;
          stab_d  = SW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Shadow capture, frame publication and scan timeout. A capture in the
  // same cycle as the timeout wins; a frame clear keeps a coincident capture.
  always_comb begin
    sh_nib_d   = sh_nib_q;
    sh_blank_d = sh_blank_q;
    sh_bad_d   = sh_bad_q;
    seen_d     = seen_q;
    d_d        = d_q;
    blank_d    = blank_q;
    bad_d      = bad_q;
    lost_d     = lost_q;
    to_cnt_d   = to_cnt_q;
    frame      = (seen_q == 4'b1111);
    fv_d       = frame;

    if (frame) begin
      d_d     = sh_nib_q;
      blank_d = sh_blank_q;
      bad_d   = sh_bad_q;
      seen_d  = '0;
    end

    if (capture) begin
      to_cnt_d = '0;
      lost_d   = 1'b0;
    end else begin
      if (to_cnt_q != CW'(TIMEOUT_CYCLES)) to_cnt_d = to_cnt_q + CW'(1);
      if (to_cnt_d == CW'(TIMEOUT_CYCLES)) begin
        lost_d = 1'b1;
        seen_d = '0;
      end
    end

    if (capture) begin
      sh_nib_d[sel_idx]   = dec.nib;
      sh_blank_d[sel_idx] = dec.blank;
      sh_bad_d[sel_idx]   = dec.bad;
      seen_d[sel_idx]     = 1'b1;
    end
  end

  // All state and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      prev_q     <= '0;
      state_q    <= S_IDLE;
      stab_q     <= '0;
      to_cnt_q   <= '0;
      sh_nib_q   <= '0;
      sh_blank_q <= '0;
      sh_bad_q   <= '0;
      seen_q     <= '0;
      d_q        <= '0;
      blank_q    <= '0;
      bad_q      <= '0;
      fv_q       <= 1'b0;
      lost_q     <= 1'b0;
    end else begin
      sync1_q    <= {bus.AN3, bus.AN2, bus.AN1, bus.AN0, bus.C};
      sync2_q    <= sync1_q;
      prev_q     <= sync2_q;
      state_q    <= state_d;
      stab_q     <= stab_d;
      to_cnt_q   <= to_cnt_d;
      sh_nib_q   <= sh_nib_d;
      sh_blank_q <= sh_blank_d;
      sh_bad_q   <= sh_bad_d;
      seen_q     <= seen_d;
      d_q        <= d_d;
      blank_q    <= blank_d;
      bad_q      <= bad_d;
      fv_q       <= fv_d;
      lost_q     <= lost_d;
    end
  end

  assign bus.D3          = d_q[3];
  assign bus.D2          = d_q[2];
  assign bus.D1          = d_q[1];
  assign bus.D0          = d_q[0];
  assign bus.blank       = blank_q;
  assign bus.bad         = bad_q;
  assign bus.frame_valid = fv_q;
  assign bus.scan_lost   = lost_q;

endmodule

// File: tb/tb_ssd_scan_decoder.sv
// Directed self-checking bench for ssd_scan_decoder.
module tb_ssd_scan_decoder;
  import ssd_scan_decoder_pkg::*;

  localparam int DWELL = 200;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;
  int   fv_cnt = 0;
  int   fv0;

  ssd_scan_decoder_if bus ();

  ssd_scan_decoder #(
    .STABLE_CYCLES  (16),
    .TIMEOUT_CYCLES (1000),
    .CW             (20)
  ) dut (
    .clk (clk),
    .rst (rst_n),
    .bus (bus)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (bus.frame_valid === 1'b1) fv_cnt++;

  // Independent active-low {g..a} encoder for stimulus.
  function automatic logic [6:0] seg_of(input logic [3:0] n);
    case (n)
      4'h0: seg_of = 7'h40; 4'h1: seg_of = 7'h79; 4'h2: seg_of = 7'h24; 4'h3: seg_of = 7'h30;
      4'h4: seg_of = 7'h19; 4'h5: seg_of = 7'h12; 4'h6: seg_of = 7'h02; 4'h7: seg_of = 7'h78;
      4'h8: seg_of = 7'h00; 4'h9: seg_of = 7'h10; 4'hA: seg_of = 7'h08; 4'hB: seg_of = 7'h03;
      4'hC: seg_of = 7'h46; 4'hD: seg_of = 7'h21; 4'hE: seg_of = 7'h06; default: seg_of = 7'h0E;
    endcase
  endfunction

  task automatic set_bus(input logic [3:0] an, input logic [6:0] c);
    {bus.AN3, bus.AN2, bus.AN1, bus.AN0} = an;
    bus.C = c;
  endtask

  task automatic drive_digit(input int idx, input logic [6:0] c, input int cycles);
    logic [3:0] an;
    an = 4'b1111;
    an[idx] = 1'b0;
    @(negedge clk);
    set_bus(an, c);
    repeat (cycles) @(negedge clk);
  endtask

  task automatic test_reset();
    set_bus(4'b1111, 7'h7F);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({bus.D3, bus.D2, bus.D1, bus.D0, bus.blank, bus.bad, bus.frame_valid, bus.scan_lost} !== 26'h0) begin
      failures++;
      $display("FAIL reset_outputs got=%h exp=0", {bus.D3, bus.D2, bus.D1, bus.D0, bus.blank, bus.bad, bus.frame_valid, bus.scan_lost});
    end
    rst_n = 1'b1;
  endtask

  task automatic test_clean_scan();
    fv0 = fv_cnt;
    drive_digit(0, seg_of(4'h4), DWELL);
    drive_digit(1, seg_of(4'h3), DWELL);
    drive_digit(2, seg_of(4'h2), DWELL);
    checks++;
    if (fv_cnt - fv0 !== 0) begin failures++; $display("FAIL clean_early_frame got=%0d exp=0", fv_cnt - fv0); end
    drive_digit(3, seg_of(4'h1), DWELL);
    checks++;
    if (fv_cnt - fv0 !== 1) begin failures++; $display("FAIL clean_frame_count got=%0d exp=1", fv_cnt - fv0); end
    checks++;
    if ({bus.D3, bus.D2, bus.D1, bus.D0} !== 16'h1234) begin
      failures++; $display("FAIL clean_digits got=%h exp=1234", {bus.D3, bus.D2, bus.D1, bus.D0});
    end
    checks++;
    if ({bus.blank, bus.bad} !== 8'h00) begin failures++; $display("FAIL clean_flags got=%h exp=00", {bus.blank, bus.bad}); end
  endtask

  task automatic test_glitch();
    logic [6:0] c8;
    logic [6:0] c8g;
    c8 = seg_of(4'h8);
    c8g = c8;
    c8g[6] = ~c8g[6];
    fv0 = fv_cnt;
    drive_digit(0, c8, 5);
    for (int i = 0; i < 10; i++) begin
      bus.C = c8g;
      repeat (5) @(negedge clk);
      bus.C = c8;
      repeat (5) @(negedge clk);
    end
    repeat (DWELL) @(negedge clk);
    drive_digit(1, seg_of(4'h5), DWELL);
    drive_digit(2, seg_of(4'h6), DWELL);
    drive_digit(3, seg_of(4'h7), DWELL);
    checks++;
    if (fv_cnt - fv0 !== 1) begin failures++; $display("FAIL glitch_frame_count got=%0d exp=1", fv_cnt - fv0); end
    checks++;
    if ({bus.D3, bus.D2, bus.D1, bus.D0} !== 16'h7658) begin
      failures++; $display("FAIL glitch_digits got=%h exp=7658", {bus.D3, bus.D2, bus.D1, bus.D0});
    end
  endtask

  task automatic test_recapture();
    fv0 = fv_cnt;
    drive_digit(0, seg_of(4'h3), DWELL);
    drive_digit(1, seg_of(4'h4), DWELL);
    drive_digit(0, seg_of(4'h9), DWELL);
    drive_digit(2, seg_of(4'h5), DWELL);
    drive_digit(3, seg_of(4'h6), DWELL);
    checks++;
    if (fv_cnt - fv0 !== 1) begin failures++; $display("FAIL recap_frame_count got=%0d exp=1", fv_cnt - fv0); end
    checks++;
    if ({bus.D3, bus.D2, bus.D1, bus.D0} !== 16'h6549) begin
      failures++; $display("FAIL recap_digits got=%h exp=6549", {bus.D3, bus.D2, bus.D1, bus.D0});
    end
  endtask

  task automatic test_blank_bad();
    drive_digit(0, seg_of(4'hF), DWELL);
    drive_digit(1, 7'h55, DWELL);
    drive_digit(2, 7'h7F, DWELL);
    drive_digit(3, seg_of(4'hF), DWELL);
    checks++;
    if (bus.blank !== 4'b0100) begin failures++; $display("FAIL blank_mask got=%b exp=0100", bus.blank); end
    checks++;
    if (bus.bad !== 4'b0010) begin failures++; $display("FAIL bad_mask got=%b exp=0010", bus.bad); end
    checks++;
    if ({bus.D3, bus.D2, bus.D1, bus.D0} !== 16'hF00F) begin
      failures++; $display("FAIL blank_bad_digits got=%h exp=f00f", {bus.D3, bus.D2, bus.D1, bus.D0});
    end
  endtask

  task automatic test_overlap();
    fv0 = fv_cnt;
    @(negedge clk);
    set_bus(4'b1100, seg_of(4'h2));
    repeat (500) @(negedge clk);
    checks++;
    if (bus.scan_lost !== 1'b0) begin failures++; $display("FAIL overlap_early_lost got=%b exp=0", bus.scan_lost); end
    repeat (2500) @(negedge clk);
    checks++;
    if (bus.scan_lost !== 1'b1) begin failures++; $display("FAIL overlap_lost got=%b exp=1", bus.scan_lost); end
    checks++;
    if (dut.state_q !== S_IDLE) begin failures++; $display("FAIL overlap_state got=%0d exp=%0d", dut.state_q, S_IDLE); end
    checks++;
    if (fv_cnt - fv0 !== 0) begin failures++; $display("FAIL overlap_frames got=%0d exp=0", fv_cnt - fv0); end
    checks++;
    if ({bus.D3, bus.D2, bus.D1, bus.D0} !== 16'hF00F) begin
      failures++; $display("FAIL overlap_hold_digits got=%h exp=f00f", {bus.D3, bus.D2, bus.D1, bus.D0});
    end
  endtask

  task automatic test_recovery();
    fv0 = fv_cnt;
    drive_digit(0, seg_of(4'hF), 5);
    checks++;
    if (bus.scan_lost !== 1'b1) begin failures++; $display("FAIL recov_lost_before got=%b exp=1", bus.scan_lost); end
    repeat (35) @(negedge clk);
    checks++;
    if (bus.scan_lost !== 1'b0) begin failures++; $display("FAIL recov_lost_cleared got=%b exp=0", bus.scan_lost); end
    repeat (DWELL - 40) @(negedge clk);
    drive_digit(1, seg_of(4'h0), DWELL);
    drive_digit(2, seg_of(4'hF), DWELL);
    drive_digit(3, seg_of(4'h0), DWELL);
    checks++;
    if (fv_cnt - fv0 !== 1) begin failures++; $display("FAIL recov_frame_count got=%0d exp=1", fv_cnt - fv0); end
    checks++;
    if ({bus.D3, bus.D2, bus.D1, bus.D0} !== 16'h0F0F) begin
      failures++; $display("FAIL recov_digits got=%h exp=0f0f", {bus.D3, bus.D2, bus.D1, bus.D0});
    end
  endtask

  task automatic test_async_reset();
    drive_digit(0, seg_of(4'h1), DWELL);
    drive_digit(1, seg_of(4'h2), DWELL);
    drive_digit(2, seg_of(4'h5), 5);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.D3, bus.D2, bus.D1, bus.D0, bus.blank, bus.bad, bus.frame_valid, bus.scan_lost} !== 26'h0) begin
      failures++;
      $display("FAIL areset_outputs got=%h exp=0", {bus.D3, bus.D2, bus.D1, bus.D0, bus.blank, bus.bad, bus.frame_valid, bus.scan_lost});
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    fv0 = fv_cnt;
    repeat (DWELL) @(negedge clk);
    drive_digit(3, seg_of(4'h9), DWELL);
    checks++;
    if (fv_cnt - fv0 !== 0) begin failures++; $display("FAIL areset_partial_frame got=%0d exp=0", fv_cnt - fv0); end
    drive_digit(0, seg_of(4'h1), DWELL);
    drive_digit(1, seg_of(4'h2), DWELL);
    checks++;
    if (fv_cnt - fv0 !== 1) begin failures++; $display("FAIL areset_frame_count got=%0d exp=1", fv_cnt - fv0); end
    checks++;
    if ({bus.D3, bus.D2, bus.D1, bus.D0} !== 16'h9521) begin
      failures++; $display("FAIL areset_digits got=%h exp=9521", {bus.D3, bus.D2, bus.D1, bus.D0});
    end
  endtask

  initial begin
    test_reset();
    test_clean_scan();
    test_glitch();
    test_recapture();
    test_blank_bad();
    test_overlap();
    test_recovery();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
